// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg: state encoding and width limit shared by the serial adder files.
package serial_adder_pkg;
    localparam int MAX_WIDTH = 32;
    typedef enum logic [1:0] {IDLE, LOAD, CALC, SEND} state_e;
endpackage

// File: rtl/serial_adder_n_piso.sv
// sa_piso: parallel-load, MSB-first shift register; clear beats load, load beats shift.
module sa_piso #(
    parameter int W = 9
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr_i,
    input  logic         load_i,
    input  logic         shift_i,
    input  logic [W-1:0] data_i,
    output logic         msb_o
);
    logic [W-1:0] data_q, data_d;

    always_comb data_d = clr_i ? '0 : load_i ? data_i : shift_i ? data_q << 1 : data_q;

    always_ff @(posedge clk) begin
        if (rst) data_q <= '0;
        else     data_q <= data_d;
    end

    assign msb_o = data_q[W-1];
endmodule

// File: rtl/serial_adder_n.sv
// serial_adder_n: MSB-first bit-serial add/subtract producing a WIDTH+1-bit serial result frame.
// Define SERIAL_ADDER_SAT_EN to saturate on carry (add) or borrow (subtract).
module serial_adder_n
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic en_i,
    input  logic sub_i,
    input  logic ina,
    input  logic inb,
    output logic busy_o,
    output logic en_o,
    output logic out
);
    localparam int CW = $clog2(WIDTH + 2);
    localparam logic [CW-1:0] LAST_IN  = CW'(WIDTH - 1);
    localparam logic [CW-1:0] LAST_OUT = CW'(WIDTH);

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic             sub_q, sub_d, en_q, en_d, out_q, out_d;
    logic [WIDTH:0]   raw, res;
    logic             cap, load, shift, msb;

    assign raw = sub_q ? {1'b0, a_q} - {1'b0, b_q} : {1'b0, a_q} + {1'b0, b_q};
`ifdef SERIAL_ADDER_SAT_EN
    assign res = !raw[WIDTH] ? raw : sub_q ? '0 : {1'b0, {WIDTH{1'b1}}};
`else
    assign res = raw;
`endif

    // one counter serves both phases: bits captured in LOAD, bits sent in SEND
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sub_d   = sub_q;
        cap     = 1'b0;
        load    = 1'b0;
        shift   = 1'b0;
        case (state_q)
            IDLE: if (en_i) begin
                cap     = 1'b1;
                sub_d   = sub_i;
                cnt_d   = CW'(1);
                state_d = (WIDTH == 1) ? CALC : LOAD;
            end
            LOAD: begin
                cap     = 1'b1;
                cnt_d   = (cnt_q == LAST_IN) ? '0 : cnt_q + 1'b1;
                state_d = (cnt_q == LAST_IN) ? CALC : LOAD;
            end
            CALC: begin
                load    = 1'b1;
                cnt_d   = '0;
                state_d = SEND;
            end
            SEND: begin
                shift   = 1'b1;
                cnt_d   = (cnt_q == LAST_OUT) ? '0 : cnt_q + 1'b1;
                state_d = (cnt_q == LAST_OUT) ? IDLE : SEND;
            end
        endcase
        a_d   = cap ? (a_q << 1) | WIDTH'(ina) : a_q;
        b_d   = cap ? (b_q << 1) | WIDTH'(inb) : b_q;
        en_d  = (state_q == SEND);
        out_d = (state_q == SEND) && msb;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            sub_q   <= 1'b0;
            en_q    <= 1'b0;
            out_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sub_q   <= sub_d;
            en_q    <= en_d;
            out_q   <= out_d;
        end
    end

    sa_piso #(.W(WIDTH + 1)) u_piso (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (state_q == IDLE),
        .load_i (load),
        .shift_i(shift),
        .data_i (res),
        .msb_o  (msb)
    );

    assign busy_o = (state_q != IDLE);
    assign en_o   = en_q;
    assign out    = out_q;
endmodule
